// File: rtl/ram8_stack_ctrl.sv
// ram8_stack_ctrl: LIFO operand stack built on an 8 x 32 single-port RAM.
// Push/pop requests from the expression evaluator become RAM write/read
// transactions. The controller reports occupancy, full/empty status and
// sticky overflow/underflow flags.
//
// Handshake: a request (push or pop) is taken only in a cycle where
// ready=1 at the rising edge. ready is high only while the FSM is idle.
// Requests presented while ready=0 are dropped, not queued. A pop result is
// marked by a one-cycle pop_valid pulse. That pulse coincides with ready=1,
// so the next request can be taken in the same cycle.
module ram8_stack_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_en,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] SP_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] SP_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RWAIT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // sp is the next free address; it spans 0..DEPTH, so it is one bit wider
  // than the RAM address.
  logic [ADDR_WIDTH:0]   r_sp;
  logic [ADDR_WIDTH:0]   w_sp_nxt;
  logic [ADDR_WIDTH:0]   w_sp_dec;

  logic                  r_ram_en;
  logic                  r_ram_rw;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_in;
  logic [DATA_WIDTH-1:0] r_pop_data;
  logic                  r_pop_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_ram_en_nxt;
  logic                  w_ram_rw_nxt;
  logic [ADDR_WIDTH-1:0] w_ram_address_nxt;
  logic [DATA_WIDTH-1:0] w_ram_in_nxt;
  logic [DATA_WIDTH-1:0] w_pop_data_nxt;
  logic                  w_pop_valid_nxt;
  logic                  w_overflow_nxt;
  logic                  w_underflow_nxt;

  logic                  w_full;
  logic                  w_empty;

  // Status is derived directly from the stack pointer.
  assign w_full   = (r_sp == DEPTH_V);
  assign w_empty  = (r_sp == SP_ZERO);
  assign w_sp_dec = r_sp - SP_ONE;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and next values for every registered output
  always_comb begin
    w_state_nxt       = r_state;
    w_sp_nxt          = r_sp;
    w_ram_en_nxt      = 1'b0;
    w_ram_rw_nxt      = r_ram_rw;
    w_ram_address_nxt = r_ram_address;
    w_ram_in_nxt      = r_ram_in;
    w_pop_data_nxt    = r_pop_data;
    w_pop_valid_nxt   = 1'b0;
    w_overflow_nxt    = r_overflow;
    w_underflow_nxt   = r_underflow;

    case (r_state)
      S_IDLE: begin
        // Push wins when both requests arrive together. The pop is dropped
        // silently, and the requester has to issue it again.
        if (push) begin
          if (!w_full) begin
            w_state_nxt       = S_WRITE;
            w_ram_en_nxt      = 1'b1;
            w_ram_rw_nxt      = 1'b1;
            w_ram_address_nxt = r_sp[ADDR_WIDTH-1:0];
            w_ram_in_nxt      = push_data;
          end else begin
            w_overflow_nxt    = 1'b1;
          end
        end else if (pop) begin
          if (!w_empty) begin
            w_state_nxt       = S_READ;
            w_ram_en_nxt      = 1'b1;
            w_ram_rw_nxt      = 1'b0;
            w_ram_address_nxt = w_sp_dec[ADDR_WIDTH-1:0];
          end else begin
            w_underflow_nxt   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // The RAM commits the write on this edge.
        w_sp_nxt    = r_sp + SP_ONE;
        w_state_nxt = S_IDLE;
      end
      S_READ: begin
        // The RAM samples the read address on this edge. The data is
        // available one cycle later.
        w_state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        w_pop_data_nxt  = ram_out;
        w_pop_valid_nxt = 1'b1;
        w_sp_nxt        = w_sp_dec;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered datapath: stack pointer, RAM drive, pop result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp          <= '0;
      r_ram_en      <= 1'b0;
      r_ram_rw      <= 1'b0;
      r_ram_address <= '0;
      r_ram_in      <= '0;
      r_pop_data    <= '0;
      r_pop_valid   <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_sp          <= w_sp_nxt;
      r_ram_en      <= w_ram_en_nxt;
      r_ram_rw      <= w_ram_rw_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_in      <= w_ram_in_nxt;
      r_pop_data    <= w_pop_data_nxt;
      r_pop_valid   <= w_pop_valid_nxt;
      r_overflow    <= w_overflow_nxt;
      r_underflow   <= w_underflow_nxt;
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_sp;
  assign pop_data    = r_pop_data;
  assign pop_valid   = r_pop_valid;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign ram_en      = r_ram_en;
  assign ram_rw      = r_ram_rw;
  assign ram_address = r_ram_address;
  assign ram_in      = r_ram_in;
  assign dbg_state   = r_state;

endmodule

// File: doc/ram8_stack_ctrl.md
Name: ram8_stack_ctrl

Overview:
- Initiator-side controller for the 8-entry × 32-bit RAM block, `RAM8_32BIT`.
- Turns push/pop requests from the expression evaluator into RAM transactions on the RAM's en/rw/address/in/out interface:
  - write: rw=1
  - read: rw=0, data appears on out after the sampling edge
- Presents a LIFO operand stack with full/empty status, occupancy count and sticky overflow/underflow flags.
- Sits between the expression datapath and the RAM instance.

Parameters:
DATA_WIDTH, 32, word width; matches RAM in/out.
ADDR_WIDTH, 3, RAM address width; DEPTH = 2**ADDR_WIDTH = 8.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  synchronous active-high reset.
push  input  1  push request; sampled only when ready=1.
pop  input  1  pop request; sampled only when ready=1.
push_data  input  DATA_WIDTH  word to push; captured with push.
ready  output  1  controller idle, request accepted this cycle.
pop_data  output  DATA_WIDTH  last popped word; holds until next pop completes.
pop_valid  output  1  one-cycle pulse, pop_data updated.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  ADDR_WIDTH+1  current occupancy, 0..8.
overflow  output  1  sticky: push attempted while full.
underflow  output  1  sticky: pop attempted while empty.
ram_en  output  1  RAM enable.
ram_rw  output  1  1=write, 0=read.
ram_address  output  ADDR_WIDTH  RAM address.
ram_in  output  DATA_WIDTH  RAM write data.
ram_out  input  DATA_WIDTH  RAM read data; valid the cycle after the read-sampling edge.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst), checked at posedge before all else.
- Reset values:
  - state=IDLE, sp=0
  - count=0, empty=1, full=0
  - ready=1, pop_valid=0, pop_data=0
  - overflow=0, underflow=0
  - ram_en=0, ram_rw=0, ram_address=0, ram_in=0
- Reset mid-transaction aborts it: the write may or may not land in RAM, stack is logically emptied, no pop_valid is issued.
- Stack pointer: sp is the next free address, and count = sp as ADDR_WIDTH+1 bits. Push writes address sp; pop reads address sp-1.
- RAM-facing outputs are registered; ram_en=0 in every state except WRITE and READ.
- FSM states: IDLE, WRITE, READ, RWAIT. ready=1 only in IDLE.
- IDLE:
  - push=1, full=0 → WRITE; latch ram_in=push_data, ram_address=sp[ADDR_WIDTH-1:0], ram_rw=1, ram_en=1.
  - push=1, full=1 → stay IDLE, overflow<=1, no RAM access.
  - push=0, pop=1, empty=0 → READ; ram_address=sp-1, ram_rw=0, ram_en=1.
  - push=0, pop=1, empty=1 → stay IDLE, underflow<=1.
  - push=1 and pop=1 → push has priority; pop is dropped (no flag) and must be re-requested.
- WRITE: RAM samples at the end of this cycle. At that edge: sp<=sp+1, ram_en<=0 → IDLE. Push latency is 2 cycles, request to ready.
- READ: RAM samples at the end of this cycle; ram_en<=0 → RWAIT.
- RWAIT: at the end of this cycle: pop_data<=ram_out, sp<=sp-1, pop_valid<=1 → IDLE. Pop latency is 3 cycles, request to pop_valid.
- pop_valid:
  - high exactly during the first IDLE cycle after RWAIT;
  - a new request may be accepted in that same cycle.
- full/empty/count are combinational from sp and update on the edge that completes WRITE/RWAIT.
- Boundaries:
  - push at count=7 writes address 7 → count=8, full=1.
  - the address never wraps; sp cannot exceed DEPTH or go below 0.
- overflow/underflow stay set until rst, and do not block further legal operations.
- push_data/pop while not ready are ignored; no queuing.

Test Plan:
- Reset → count=0, empty=1, ready=1, ram_en=0, pop_valid=0, flags=0.
- Push 123 from empty → next cycle ram_en=1, ram_rw=1, ram_address=0, ram_in=123; then count=1, ready=1.
- Push 0..7 (values 10,20,...,80) → ram_address sequence 0..7, full=1 after 8th; 9th push (999) → overflow=1, no ram_en pulse, count=8.
- From full, pop ×8 → read addresses 7 down to 0; pop_data 80,70,...,10, each with a single pop_valid pulse 3 cycles after request; empty=1 at end.
- Pop while empty → underflow=1, no RAM access, pop_data unchanged.
- Push and pop asserted together at count=2 → push only, count=3, no read issued.
- rst asserted during the READ state → next cycle state IDLE, count=0, ram_en=0, no pop_valid.
